// File: rtl/board_pkg.sv
// Shared constants, types and helpers for the 6x6 card-board game controller.
package board_pkg;

  localparam int unsigned N_CARDS = 36;
  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 6;
  localparam int unsigned N_PAIRS = 18;
  localparam int unsigned TYPE_W  = 4;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned PAIRS_W = 5;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [TYPE_W-1:0]  type_t;
  typedef logic [N_CARDS-1:0] board_t;

  typedef enum logic [2:0] {
    StIdle,
    StOne,
    StFetchA,
    StFetchB,
    StCompare,
    StHold
  } state_e;

  // One-hot board vector with only the given card's bit set.
  function automatic board_t card_bit(input idx_t idx);
    return board_t'(1) << idx;
  endfunction

endpackage

// File: rtl/board_cursor.sv
// Cursor register kept as row/column pair; moves wrap within their own axis.
module board_cursor
  import board_pkg::*;
#(
  parameter int unsigned CURSOR_INIT = 0
) (
  input  logic clk100_in,
  input  logic rst,
  input  logic i_en,
  input  logic i_up,
  input  logic i_down,
  input  logic i_left,
  input  logic i_right,
  output idx_t o_cursor
);

  localparam logic [2:0] RowInit = 3'(CURSOR_INIT / COLS);
  localparam logic [2:0] ColInit = 3'(CURSOR_INIT % COLS);
  localparam logic [2:0] RowLim  = 3'(ROWS);
  localparam logic [2:0] ColLim  = 3'(COLS);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic [2:0] w_row_d;
  logic [2:0] w_col_d;

  function automatic logic [2:0] step_wrap(input logic [2:0] v, input logic [2:0] lim,
                                           input logic inc);
    if (inc) begin
      return (v == lim - 3'd1) ? 3'd0 : v + 3'd1;
    end
    return (v == 3'd0) ? lim - 3'd1 : v - 3'd1;
  endfunction

  // Up > down > left > right; only one move per cycle.
  always_comb begin
    w_row_d = r_row;
    w_col_d = r_col;
    if (i_en) begin
      if (i_up) begin
        w_row_d = step_wrap(r_row, RowLim, 1'b0);
      end else if (i_down) begin
        w_row_d = step_wrap(r_row, RowLim, 1'b1);
      end else if (i_left) begin
        w_col_d = step_wrap(r_col, ColLim, 1'b0);
      end else if (i_right) begin
        w_col_d = step_wrap(r_col, ColLim, 1'b1);
      end
    end
  end

  always_ff @(posedge clk100_in) begin
    if (rst) begin
      r_row <= RowInit;
      r_col <= ColInit;
    end else begin
      r_row <= w_row_d;
      r_col <= w_col_d;
    end
  end

  assign o_cursor = idx_t'(r_row) * idx_t'(COLS) + idx_t'(r_col);

endmodule

// File: rtl/board_ctrl.sv
// Game-state controller: cursor moves, card selection, pair check against the
// registered card-type memory, and the hidden/blink/select buses for display.
module board_ctrl
  import board_pkg::*;
#(
  parameter int unsigned MISMATCH_HOLD = 50_000_000,
  parameter int unsigned CURSOR_INIT   = 0
) (
  input  logic                 clk100_in,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [IDX_W-1:0]     type_addr,
  input  logic [TYPE_W-1:0]    type_data,
  output logic [N_CARDS-1:0]   hidden_bus,
  output logic [N_CARDS-1:0]   blink_bus,
  output logic [N_CARDS-1:0]   sel_bus,
  output logic [IDX_W-1:0]     cursor,
  output logic [PAIRS_W-1:0]   pairs_left,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned HoldW = (MISMATCH_HOLD > 1) ? $clog2(MISMATCH_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(MISMATCH_HOLD - 1);

  state_e             r_state;
  state_e             w_state_d;
  idx_t               r_a;
  idx_t               r_b;
  type_t              r_type_a;
  idx_t               r_type_addr;
  board_t             r_hidden;
  board_t             r_sel;
  logic [PAIRS_W-1:0] r_pairs;
  logic [HoldW-1:0]   r_hold;
  logic               r_done;

  idx_t   w_cursor;
  board_t w_cur_bit;
  board_t w_pair_bits;
  logic   w_cur_hidden;
  logic   w_accept;
  logic   w_sel_ok;
  logic   w_match;
  logic   w_hold_zero;

  logic   w_busy;
  logic   w_take_a;
  logic   w_drop_a;
  logic   w_take_b;
  logic   w_addr_b;
  logic   w_cap_a;
  logic   w_pair_hit;
  logic   w_hold_load;
  logic   w_hold_dec;
  logic   w_pair_clear;

  assign w_cur_bit    = card_bit(w_cursor);
  assign w_pair_bits  = card_bit(r_a) | card_bit(r_b);
  assign w_cur_hidden = |(r_hidden & w_cur_bit);
  assign w_sel_ok     = w_accept & btn_sel & ~w_cur_hidden;
  assign w_match      = (type_data == r_type_a);
  assign w_hold_zero  = (r_hold == '0);

  // Selection outranks every move, so the cursor is frozen on a select cycle.
  board_cursor #(
    .CURSOR_INIT (CURSOR_INIT)
  ) u_cursor (
    .clk100_in (clk100_in),
    .rst       (rst),
    .i_en      (w_accept & ~btn_sel),
    .i_up      (btn_up),
    .i_down    (btn_down),
    .i_left    (btn_left),
    .i_right   (btn_right),
    .o_cursor  (w_cursor)
  );

  always_ff @(posedge clk100_in) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_sel_ok) w_state_d = StOne;
      end
      StOne: begin
        if (w_sel_ok) w_state_d = (w_cursor == r_a) ? StIdle : StFetchA;
      end
      StFetchA:  w_state_d = StFetchB;
      StFetchB:  w_state_d = StCompare;
      StCompare: w_state_d = w_match ? StIdle : StHold;
      StHold: begin
        if (w_hold_zero) w_state_d = StIdle;
      end
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_take_a     = 1'b0;
    w_drop_a     = 1'b0;
    w_take_b     = 1'b0;
    w_addr_b     = 1'b0;
    w_cap_a      = 1'b0;
    w_pair_hit   = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_dec   = 1'b0;
    w_pair_clear = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_accept = ~r_done;
        w_take_a = w_sel_ok;
      end
      StOne: begin
        w_accept = ~r_done;
        w_drop_a = w_sel_ok & (w_cursor == r_a);
        w_take_b = w_sel_ok & (w_cursor != r_a);
      end
      StFetchA: begin
        w_busy   = 1'b1;
        w_addr_b = 1'b1;
      end
      StFetchB: begin
        w_busy  = 1'b1;
        w_cap_a = 1'b1;
      end
      StCompare: begin
        w_busy      = 1'b1;
        w_pair_hit  = w_match;
        w_hold_load = ~w_match;
      end
      StHold: begin
        w_busy       = 1'b1;
        w_hold_dec   = ~w_hold_zero;
        w_pair_clear = w_hold_zero;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk100_in) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_type_a    <= '0;
      r_type_addr <= '0;
      r_hidden    <= '0;
      r_sel       <= '0;
      r_pairs     <= PAIRS_W'(N_PAIRS);
      r_hold      <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_take_a) begin
        r_a   <= w_cursor;
        r_sel <= r_sel | w_cur_bit;
      end
      if (w_drop_a) begin
        r_sel <= r_sel & ~w_cur_bit;
      end
      // The A address goes out together with B's selection so the fetch pipeline
      // lines up with the one-cycle memory latency.
      if (w_take_b) begin
        r_b         <= w_cursor;
        r_sel       <= r_sel | w_cur_bit;
        r_type_addr <= r_a;
      end
      if (w_addr_b) begin
        r_type_addr <= r_b;
      end
      if (w_cap_a) begin
        r_type_a <= type_data;
      end
      if (w_pair_hit) begin
        r_hidden <= r_hidden | w_pair_bits;
        r_sel    <= r_sel & ~w_pair_bits;
        if (r_pairs != '0) begin
          r_pairs <= r_pairs - PAIRS_W'(1);
        end
        if (r_pairs <= PAIRS_W'(1)) begin
          r_done <= 1'b1;
        end
      end
      if (w_hold_load) begin
        r_hold <= HoldLoad;
      end else if (w_hold_dec) begin
        r_hold <= r_hold - HoldW'(1);
      end
      if (w_pair_clear) begin
        r_sel <= r_sel & ~w_pair_bits;
      end
    end
  end

  assign type_addr  = r_type_addr;
  assign hidden_bus = r_hidden;
  assign blink_bus  = w_cur_bit;
  assign sel_bus    = r_sel;
  assign cursor     = w_cursor;
  assign pairs_left = r_pairs;
  assign busy       = w_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against a game-level model of the board.
module tb_board_ctrl;

  localparam int unsigned Hold = 4;
  localparam logic [4:0] BSel   = 5'b10000;
  localparam logic [4:0] BUp    = 5'b01000;
  localparam logic [4:0] BDown  = 5'b00100;
  localparam logic [4:0] BLeft  = 5'b00010;
  localparam logic [4:0] BRight = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_up, b_down, b_left, b_right, b_sel;
  logic [5:0]  type_addr;
  logic [3:0]  type_data;
  logic [35:0] hidden_bus, blink_bus, sel_bus;
  logic [5:0]  cursor;
  logic [4:0]  pairs_left;
  logic        busy, done;

  logic [3:0]  mem [36];

  always #5 clk = ~clk;
  always @(posedge clk) type_data <= mem[type_addr];

  board_ctrl #(
    .MISMATCH_HOLD (Hold),
    .CURSOR_INIT   (0)
  ) dut (
    .clk100_in  (clk),
    .rst        (rst),
    .btn_up     (b_up),
    .btn_down   (b_down),
    .btn_left   (b_left),
    .btn_right  (b_right),
    .btn_sel    (b_sel),
    .type_addr  (type_addr),
    .type_data  (type_data),
    .hidden_bus (hidden_bus),
    .blink_bus  (blink_bus),
    .sel_bus    (sel_bus),
    .cursor     (cursor),
    .pairs_left (pairs_left),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game-level model: cursor as row/col, pending check as a countdown of busy cycles.
  int          m_row, m_col, m_a, m_b, m_cnt, m_pairs, m_addr, cur;
  bit          m_have_a, m_match, m_done, m_addr_pend;
  logic [35:0] m_hidden, m_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_row = 0; m_col = 0; m_a = 0; m_b = 0; m_cnt = 0; m_pairs = 18; m_addr = 0;
      m_have_a = 0; m_match = 0; m_done = 0; m_addr_pend = 0;
      m_hidden = '0; m_sel = '0;
    end else begin
      if (m_addr_pend) begin
        m_addr = m_b;
        m_addr_pend = 0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_match) begin
            m_hidden[m_a] = 1'b1;
            m_hidden[m_b] = 1'b1;
            if (m_pairs > 0) m_pairs--;
            if (m_pairs == 0) m_done = 1;
          end
          m_sel[m_a] = 1'b0;
          m_sel[m_b] = 1'b0;
        end
      end else if (!m_done) begin
        cur = m_row * 6 + m_col;
        if (b_sel) begin
          if (!m_hidden[cur]) begin
            if (!m_have_a) begin
              m_sel[cur] = 1'b1; m_a = cur; m_have_a = 1;
            end else if (cur == m_a) begin
              m_sel[cur] = 1'b0; m_have_a = 0;
            end else begin
              m_sel[cur] = 1'b1; m_b = cur; m_have_a = 0;
              m_match = (mem[m_a] == mem[m_b]);
              m_cnt = m_match ? 3 : 3 + Hold;
              m_addr = m_a; m_addr_pend = 1;
            end
          end
        end else if (b_up)    m_row = (m_row + 5) % 6;
        else if (b_down)      m_row = (m_row + 1) % 6;
        else if (b_left)      m_col = (m_col + 5) % 6;
        else if (b_right)     m_col = (m_col + 1) % 6;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("cursor", cursor, m_row * 6 + m_col);
      check_eq("blink_bus", blink_bus, 36'd1 << (m_row * 6 + m_col));
      check_eq("hidden_bus", hidden_bus, m_hidden);
      check_eq("sel_bus", sel_bus, m_sel);
      check_eq("pairs_left", pairs_left, m_pairs);
      check_eq("busy", busy, m_cnt > 0);
      check_eq("done", done, m_done);
      check_eq("type_addr", type_addr, m_addr);
    end
  end

  task automatic press(input logic [4:0] b);
    {b_sel, b_up, b_down, b_left, b_right} = b;
    @(negedge clk);
    {b_sel, b_up, b_down, b_left, b_right} = '0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto(input int idx);
    for (int k = 0; k < 12 && (m_row * 6 + m_col) != idx; k++) begin
      if (m_row != idx / 6) press(BDown);
      else press(BRight);
    end
  endtask

  task automatic select_pair(input int a, input int b);
    goto(a);
    press(BSel);
    goto(b);
    press(BSel);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cursor"}, cursor, 0);
    check_eq({tag, "_hidden"}, hidden_bus, 0);
    check_eq({tag, "_sel"}, sel_bus, 0);
    check_eq({tag, "_pairs"}, pairs_left, 18);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_addr"}, type_addr, 0);
  endtask

  initial begin
    logic [3:0] tmp;
    int j;
    rst = 1'b1;
    {b_sel, b_up, b_down, b_left, b_right} = '0;
    for (int i = 0; i < 36; i++) mem[i] = 4'((i / 2) % 16);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check_reset_values("reset");
    check_eq("reset_blink", blink_bus, 36'h1);

    press(BLeft);
    check_eq("left_wrap_cursor", cursor, 5);
    check_eq("left_wrap_blink", blink_bus, 36'h20);
    press(BUp);
    check_eq("up_wrap_cursor", cursor, 35);

    // Mismatch 0/7 with a right press during the hold.
    mem[0] = 4'd2;
    mem[7] = 4'd5;
    select_pair(0, 7);
    check_eq("mis_sel_t1", sel_bus, 36'h81);
    check_eq("mis_busy_t1", busy, 1);
    check_eq("mis_addr_t1", type_addr, 0);
    press(BRight);
    check_eq("mis_addr_t2", type_addr, 7);
    idle_n(1);
    for (int k = 0; k < 4; k++) begin
      idle_n(1);
      check_eq("mis_hold_sel", sel_bus, 36'h81);
    end
    idle_n(1);
    check_eq("mis_clear_sel", sel_bus, 0);
    check_eq("mis_clear_busy", busy, 0);
    check_eq("mis_hidden", hidden_bus, 0);
    check_eq("mis_cursor", cursor, 7);

    // Match 0/1.
    mem[0] = 4'd3;
    mem[1] = 4'd3;
    select_pair(0, 1);
    idle_n(3);
    check_eq("match_hidden", hidden_bus, 36'h3);
    check_eq("match_sel", sel_bus, 0);
    check_eq("match_pairs", pairs_left, 17);
    check_eq("match_busy", busy, 0);

    // Deselect, and hidden cards ignored in both IDLE and ONE.
    goto(4);
    press(BSel);
    check_eq("desel_set", sel_bus, 36'h10);
    press(BSel);
    check_eq("desel_clr", sel_bus, 0);
    press(BSel);
    goto(0);
    press(BSel);
    check_eq("one_hidden_sel", sel_bus, 36'h10);
    check_eq("one_hidden_busy", busy, 0);
    goto(4);
    press(BSel);
    goto(1);
    press(BSel);
    check_eq("idle_hidden_sel", sel_bus, 0);
    check_eq("idle_hidden_hid", hidden_bus, 36'h3);

    // Select outranks up; then reset in the middle of a hold.
    goto(8);
    press(BSel | BUp);
    check_eq("prio_cursor", cursor, 8);
    check_eq("prio_sel", sel_bus, 36'h100);
    mem[8] = 4'd1;
    mem[9] = 4'd9;
    goto(9);
    press(BSel);
    idle_n(4);
    check_eq("hold_busy", busy, 1);
    do_reset();
    check_reset_values("midhold_rst");

    // Random traffic over a shuffled deck.
    for (int i = 0; i < 36; i++) mem[i] = 4'((i / 2) % 16);
    for (int i = 35; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = mem[i];
      mem[i] = mem[j];
      mem[j] = tmp;
    end
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else if (r < 90) begin
        press(5'(1 << $urandom_range(0, 4)));
      end else if (r < 110) begin
        press(5'($urandom_range(0, 31)));
      end else begin
        idle_n(1);
      end
    end

    // Clear the whole board.
    do_reset();
    for (int i = 0; i < 36; i++) mem[i] = 4'((i / 2) % 16);
    for (int k = 0; k < 18; k++) begin
      select_pair(2 * k, 2 * k + 1);
      idle_n(3);
    end
    check_eq("all_pairs", pairs_left, 0);
    check_eq("all_done", done, 1);
    check_eq("all_hidden", hidden_bus, 36'hF_FFFF_FFFF);
    press(BLeft);
    press(BSel);
    press(BUp);
    check_eq("done_cursor", cursor, 35);
    check_eq("done_sel", sel_bus, 0);
    check_eq("done_pairs", pairs_left, 0);
    check_eq("done_hold", done, 1);
    check_eq("done_busy", busy, 0);

    idle_n(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Game-state controller for the 6×6 card board. Turns one-cycle button pulses into cursor moves and selections, and reads card types from the card-type memory to check each selected pair. Maintains the `hidden_bus`, `blink_bus` and `sel_bus` vectors that the VGA timing block renders. Sits between the debounced button front end and the display, on the 100 MHz domain.

## Interface
Parameters:
- `MISMATCH_HOLD`, default 50_000_000: cycles a mismatched pair stays selected before being cleared. Minimum 1.
- `CURSOR_INIT`, default 0: cursor index after reset. Must be in 0..35.

Ports:
- `clk100_in`  in  1  system clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`  in  1 each  single-cycle pulses, already debounced.
- `type_addr`  out  6  card index (0..35) presented to the card-type memory.
- `type_data`  in  4  card type at `type_addr`. Registered memory: the value for an address driven in cycle k is valid in cycle k+1.
- `hidden_bus`  out  36  bit i = 1 when card i has been removed.
- `blink_bus`  out  36  one-hot at the cursor index.
- `sel_bus`  out  36  bit i = 1 when card i is currently selected.
- `cursor`  out  6  cursor index, row*6 + col.
- `pairs_left`  out  5  unmatched pairs remaining.
- `busy`  out  1  high while a pair check or mismatch hold is in progress.
- `done`  out  1  high while `pairs_left` == 0.

## Operation
- Reset values:
  - `cursor` = `CURSOR_INIT`
  - `hidden_bus` = 0, `sel_bus` = 0
  - `pairs_left` = 18
  - `busy` = 0, `done` = 0
  - `type_addr` = 0
  - state = IDLE
- `blink_bus` = 1 << `cursor`, driven combinationally from the registered cursor.
- Button priority when several pulses arrive in the same cycle: sel > up > down > left > right. Exactly one action per cycle; the other pulses are dropped.
- Cursor moves wrap within their axis:
  - up/down: row ±1 mod 6, column unchanged.
  - left/right: column ±1 mod 6, row unchanged.
- All buttons are ignored while `busy` = 1 or `done` = 1.
- States:
  - IDLE: no card selected. `btn_sel` on a non-hidden card sets its `sel_bus` bit, stores it as A, and moves to ONE. `btn_sel` on a hidden card is ignored.
  - ONE: one card selected.
    - `btn_sel` on A clears its `sel_bus` bit and returns to IDLE.
    - `btn_sel` on a hidden card is ignored.
    - `btn_sel` on any other card sets its `sel_bus` bit, stores it as B, and moves to FETCH_A.
  - FETCH_A: drive `type_addr` = A; next state FETCH_B.
  - FETCH_B: drive `type_addr` = B; capture type A; next state COMPARE.
  - COMPARE: capture type B and compare with type A.
    - Equal: set `hidden_bus` bits A and B, clear `sel_bus` bits A and B, decrement `pairs_left`, go to IDLE.
    - Not equal: load the hold counter with `MISMATCH_HOLD` − 1 and go to HOLD.
  - HOLD: count down. At 0, clear `sel_bus` bits A and B and go to IDLE.
- `busy` = 1 in FETCH_A, FETCH_B, COMPARE and HOLD.
- `pairs_left` saturates at 0. `done` is registered and asserts in the same cycle `pairs_left` becomes 0. Only `rst` leaves the `done` condition.
- The cursor never moves during a check, so a second-selected card is never hidden at the moment it is selected.
- `rst` in any state (including mid-HOLD or mid-fetch) returns every register to its reset value on the next edge. No partial update is allowed.

## Timing
- Second `btn_sel` sampled at edge t (the card becomes B):
  - `sel_bus` bit B and `busy` are visible in cycle t+1.
  - `type_addr` = A in cycle t+1 and B in cycle t+2.
  - The compare happens at the edge ending cycle t+3.
- Match: `hidden_bus`, `sel_bus` and `pairs_left` update, and `busy` = 0, in cycle t+4. The next button is accepted from cycle t+4.
- Mismatch: the `sel_bus` bits stay set for cycles t+4 through t+3+`MISMATCH_HOLD`. They clear and `busy` = 0 in cycle t+4+`MISMATCH_HOLD`.
- Cursor move and first select: outputs update one cycle after the pulse.
- `type_addr` holds its last value outside the FETCH states.

## Structure
- Shared package `board_pkg`:
  - `N_CARDS` = 36, `ROWS` = 6, `COLS` = 6, `N_PAIRS` = 18.
  - Card type width = 4.
  - The state enum: IDLE, ONE, FETCH_A, FETCH_B, COMPARE, HOLD.
- Sub-module `board_cursor`: holds the cursor register and does the wrapping row/column arithmetic, with an enable input driven low while busy.
- The FSM, the hold counter and the bus registers stay in `board_ctrl`.

## Test plan
- Reset then `btn_left` ×1 with `CURSOR_INIT` = 0 → `cursor` = 5, `blink_bus` = 36'h20. Then `btn_up` → `cursor` = 35.
- Select 0 and 1 (types 3, 3) → in cycle t+4: `hidden_bus` = 36'h3, `sel_bus` = 0, `pairs_left` = 17, `busy` = 0.
- Select 0 and 7 (types 2, 5) with `MISMATCH_HOLD` = 4 → `sel_bus` = 36'h81 for exactly 4 cycles, then 0. `hidden_bus` unchanged. `btn_right` during the hold is ignored.
- Select 4, then select 4 again → `sel_bus` returns to 0 and the state is IDLE. Select a hidden card → no change.
- `btn_sel` + `btn_up` in the same cycle → selection only; `cursor` unchanged. Then `rst` asserted in HOLD → all outputs at reset values the next cycle.
- Match all 18 pairs → `pairs_left` = 0, `done` = 1, `hidden_bus` = all ones; further button pulses cause no change.
